// File: rtl/display_pio_queue.sv
// Host PIO write queue for the display link: a FIFO of {addr, data} writes issued to the
// serializer at most once per link frame. Optional macro DISPLAY_PIO_FLUSH_ON_LINK_DOWN_EN empties the queue on link loss.
module display_pio_queue #(
    parameter int DEPTH_LOG2   = 4,
    parameter int FRAME_CYCLES = 100
) (
    input  logic                  c,
    input  logic                  r,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [3:0]            s_addr,
    input  logic [7:0]            s_data,
    input  logic                  fifostat,
    input  logic                  link_active,
    output logic                  m_wvalid,
    output logic [3:0]            m_waddr,
    output logic [7:0]            m_wdata,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0]         HOLD_LOAD = CW'(FRAME_CYCLES - 2);
    localparam logic [DEPTH_LOG2:0]   FULL_LVL  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } pio_wr_t;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLDOFF} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [DEPTH_LOG2:0]   wptr, rptr, level_nxt;
    pio_wr_t               mem [DEPTH];
    pio_wr_t               head, wr_in;
    logic                  flush, push, pop, issue, empty;

`ifdef DISPLAY_PIO_FLUSH_ON_LINK_DOWN_EN
    logic link_q;

    always_ff @(posedge c or posedge r) begin
        if (r) link_q <= 1'b0;
        else   link_q <= link_active;
    end

    assign flush = link_q & ~link_active;
`else
    assign flush = 1'b0;
`endif

    assign empty = (level == '0);
    assign head  = mem[rptr[DEPTH_LOG2-1:0]];
    assign wr_in = '{addr: s_addr, data: s_data};
    assign push  = s_valid & s_ready & ~flush;
    assign pop   = (state == ISSUE) & ~flush;
    assign issue = (state == IDLE) & (state_nxt == ISSUE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (!empty && link_active && !fifostat) state_nxt = ISSUE;
            end
            ISSUE: begin
                // Idle and issue take one cycle each, so holdoff covers the rest of the frame
                if (FRAME_CYCLES > 2) begin
                    state_nxt = HOLDOFF;
                    cnt_nxt   = HOLD_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HOLDOFF: begin
                if (cnt <= CW'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    always_comb begin
        level_nxt = level;
        if (flush)             level_nxt = '0;
        else if (push && !pop) level_nxt = level + (DEPTH_LOG2 + 1)'(1);
        else if (pop && !push) level_nxt = level - (DEPTH_LOG2 + 1)'(1);
    end

    always_ff @(posedge c) begin
        if (push) mem[wptr[DEPTH_LOG2-1:0]] <= wr_in;
    end

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            state    <= IDLE;
            cnt      <= '0;
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            s_ready  <= 1'b0;
            m_wvalid <= 1'b0;
            m_waddr  <= '0;
            m_wdata  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            level    <= level_nxt;
            // Ready follows the settled level only; a pop at full frees a slot one cycle later
            s_ready  <= (level_nxt != FULL_LVL);
            wptr     <= wptr + (DEPTH_LOG2 + 1)'(push);
            rptr     <= flush ? wptr : rptr + (DEPTH_LOG2 + 1)'(pop);
            m_wvalid <= issue;
            if (issue) begin
                m_waddr <= head.addr;
                m_wdata <= head.data;
            end
            if (s_valid && !s_ready) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_display_pio_queue.sv
// Directed bench for display_pio_queue: scoreboarded write order plus frame spacing, backpressure,
// link-down and reset checks. Define DISPLAY_PIO_FLUSH_ON_LINK_DOWN_EN to cover the flush build.
module tb_display_pio_queue;

    logic        c = 1'b0;
    logic        r = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [3:0]  s_addr = '0;
    logic [7:0]  s_data = '0;
    logic        fifostat = 1'b0;
    logic        link_active = 1'b0;
    logic        m_wvalid;
    logic [3:0]  m_waddr;
    logic [7:0]  m_wdata;
    logic [4:0]  level;
    logic        overflow;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    int          peak = 0;
    bit          track = 1'b0;
    logic [11:0] exp_q [$];
    int          pulse_cyc [$];

    display_pio_queue #(.DEPTH_LOG2(4), .FRAME_CYCLES(100)) dut (
        .c(c), .r(r), .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
        .fifostat(fifostat), .link_active(link_active), .m_wvalid(m_wvalid), .m_waddr(m_waddr),
        .m_wdata(m_wdata), .level(level), .overflow(overflow)
    );

    always #5 c = ~c;
    always @(posedge c) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Every strobe must match the oldest accepted write
    always @(negedge c) begin
        if (!r && m_wvalid) begin
            pulse_cyc.push_back(cyc);
            chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("wr_order", {m_waddr, m_wdata}, exp_q.pop_front());
        end
        if (track && int'(level) > peak) peak = int'(level);
    end

    task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
        s_valid = 1'b1; s_addr = a; s_data = d;
        exp_q.push_back({a, d});
        @(negedge c);
        s_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget, input string tag);
        int k = 0;
        while (pulse_cyc.size() < n && k < budget) begin
            @(negedge c);
            k++;
        end
        @(negedge c);
        chk(tag, pulse_cyc.size(), n);
    endtask

    task automatic check_gaps(input string tag);
        for (int i = 1; i < pulse_cyc.size(); i++) chk(tag, pulse_cyc[i] - pulse_cyc[i-1], 100);
    endtask

    initial begin
        // Reset values while r is held, before any clock edge
        #1 r = 1'b1;
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_wvalid", m_wvalid, 0);
        chk("rst_m_waddr", m_waddr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        repeat (3) @(negedge c);
        r = 1'b0;
        link_active = 1'b1;
        @(negedge c);
        chk("ready_after_rst", s_ready, 1);

        // Single write: strobe one cycle after the push edge, then level drains
        push_wr(4'd3, 8'hA5);
        chk("t1_level_after_push", level, 1);
        chk("t1_no_fallthrough", m_wvalid, 0);
        @(negedge c);
        chk("t1_wvalid", m_wvalid, 1);
        chk("t1_waddr", m_waddr, 3);
        chk("t1_wdata", m_wdata, 8'hA5);
        @(negedge c);
        chk("t1_wvalid_single", m_wvalid, 0);
        chk("t1_level_empty", level, 0);
        chk("t1_addr_hold", m_waddr, 3);
        repeat (110) @(negedge c);

        // Five back-to-back writes paced one frame apart
        pulse_cyc.delete();
        peak = 0; track = 1'b1;
        for (int i = 0; i < 5; i++) push_wr(4'(i + 8), 8'(8'h10 * i + 1));
        wait_pulses(5, 600, "t2_pulse_count");
        track = 1'b0;
        chk("t2_peak_4_or_5", 32'(peak == 4 || peak == 5), 1);
        check_gaps("t2_gap");
        repeat (105) @(negedge c);

        // Link down: fill to 16, reject the 17th, then drain in order
        link_active = 1'b0;
        pulse_cyc.delete();
        for (int i = 0; i < 16; i++) push_wr(4'(15 - i), 8'($urandom_range(0, 255)));
        chk("t3_full_ready", s_ready, 0);
        chk("t3_full_level", level, 16);
        chk("t3_no_ovf_yet", overflow, 0);
        s_valid = 1'b1; s_addr = 4'hF; s_data = 8'hEE;
        @(negedge c);
        s_valid = 1'b0;
        chk("t3_overflow", overflow, 1);
        chk("t3_level_kept", level, 16);
        chk("t3_no_issue_link_down", pulse_cyc.size(), 0);
        link_active = 1'b1;
        wait_pulses(16, 1700, "t3_pulse_count");
        check_gaps("t3_gap");
        chk("t3_ovf_sticky", overflow, 1);
        repeat (105) @(negedge c);

        // fifostat backpressure
        begin
            int t0;
            fifostat = 1'b1;
            pulse_cyc.delete();
            push_wr(4'd1, 8'h11);
            push_wr(4'd2, 8'h22);
            repeat (300) @(negedge c);
            chk("t4_held", pulse_cyc.size(), 0);
            t0 = cyc;
            fifostat = 1'b0;
            wait_pulses(2, 250, "t4_pulse_count");
            if (pulse_cyc.size() >= 2) begin
                chk("t4_first_lat", 32'(pulse_cyc[0] - t0 >= 1 && pulse_cyc[0] - t0 <= 2), 1);
                check_gaps("t4_gap");
            end
        end
        repeat (105) @(negedge c);

        // Reset mid-holdoff with 3 entries queued
        pulse_cyc.delete();
        for (int i = 0; i < 4; i++) push_wr(4'(i), 8'(8'hC0 + i));
        repeat (30) @(negedge c);
        chk("t5_one_issued", pulse_cyc.size(), 1);
        chk("t5_level_before", level, 3);
        r = 1'b1;
        #1;
        chk("t5_rst_wvalid", m_wvalid, 0);
        chk("t5_rst_level", level, 0);
        chk("t5_rst_overflow", overflow, 0);
        chk("t5_rst_ready", s_ready, 0);
        exp_q.delete();
        pulse_cyc.delete();
        @(negedge c);
        r = 1'b0;
        repeat (300) @(negedge c);
        chk("t5_no_writes", pulse_cyc.size(), 0);
        chk("t5_ready_back", s_ready, 1);

        // Link loss with 4 entries held by fifostat
        fifostat = 1'b1;
        for (int i = 0; i < 4; i++) push_wr(4'(i + 4), 8'(8'h50 + i));
        chk("t6_level_queued", level, 4);
        link_active = 1'b0;
        repeat (2) @(negedge c);
`ifdef DISPLAY_PIO_FLUSH_ON_LINK_DOWN_EN
        chk("t6_flushed", level, 0);
        exp_q.delete();
`else
        chk("t6_retained", level, 4);
`endif
        fifostat = 1'b0;
        repeat (20) @(negedge c);
        link_active = 1'b1;
        pulse_cyc.delete();
`ifdef DISPLAY_PIO_FLUSH_ON_LINK_DOWN_EN
        repeat (500) @(negedge c);
        chk("t6_no_writes", pulse_cyc.size(), 0);
`else
        wait_pulses(4, 500, "t6_pulse_count");
        check_gaps("t6_gap");
`endif
        repeat (2) @(negedge c);
        chk("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
